// File: rtl/sync_sched_pkg.sv
// Shared constants for the DATA_SYNC source-side scheduler: FSM encoding and
// the guard-counter width helper.
package sync_sched_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] LAUNCH = 2'b01;
  localparam logic [1:0] HOLD   = 2'b10;

  // The counter only ever holds a reload value minus one, so max+1 codes suffice.
  function automatic int cnt_width(input int enable_cycles, input int hold_cycles);
    int max_cnt;
    max_cnt = (enable_cycles > hold_cycles) ? enable_cycles : hold_cycles;
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/sync_bus_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       any_req
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found          = 1'b1;
        pick[cand]     = 1'b1;
        pick_idx       = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sync_bus_scheduler.sv
// Source-side scheduler sharing one DATA_SYNC bus synchronizer between NUM_REQ
// requesters: round-robin grant, enable pulse, then a fixed bus guard window.
module sync_bus_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int data_width    = 8,
  parameter int ENABLE_CYCLES = 1,
  parameter int HOLD_CYCLES   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          bus_enable,
  output logic [data_width-1:0]         unsync_bus,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    last_src
);
  import sync_sched_pkg::*;

  // state  | meaning
  // IDLE   | arbitrate; a pending request is launched on this edge
  // LAUNCH | bus_enable high, counting ENABLE_CYCLES
  // HOLD   | bus_enable low, unsync_bus frozen for HOLD_CYCLES

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(ENABLE_CYCLES, HOLD_CYCLES);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         ptr;
  logic [NUM_REQ-1:0]    pick;
  logic [IW-1:0]         pick_idx;
  logic                  any_req;
  logic [data_width-1:0] sel_word;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IW'(k)) sel_word = req_data[k*data_width +: data_width];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= IW'(NUM_REQ - 1);
      grant      <= '0;
      bus_enable <= 1'b0;
      unsync_bus <= '0;
      busy       <= 1'b0;
      last_src   <= '0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            unsync_bus <= sel_word;
            grant      <= pick;
            bus_enable <= 1'b1;
            busy       <= 1'b1;
            ptr        <= pick_idx;
            last_src   <= pick_idx;
            cnt        <= CW'(ENABLE_CYCLES - 1);
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == '0) begin
            bus_enable <= 1'b0;
            cnt        <= CW'(HOLD_CYCLES - 1);
            state      <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Unused encoding: drop the transfer and fall back to arbitration.
        default: begin
          bus_enable <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_bus_scheduler.sv
// Bench for sync_bus_scheduler: time-based arbitration model feeding a
// scoreboard, plus a behavioural 3-stage destination-side capture.
module tb_sync_bus_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int EN      = 1;
  localparam int HOLDC   = 6;
  localparam int PERIOD  = EN + HOLDC + 1;

  typedef struct {
    int            idx;
    logic [DW-1:0] word;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  clk_dst = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    keep;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [DW-1:0]         words [NUM_REQ];
  logic [NUM_REQ-1:0]    grant;
  logic                  bus_enable;
  logic [DW-1:0]         unsync_bus;
  logic                  busy;
  logic [1:0]            last_src;

  int      checks = 0;
  int      errors = 0;
  exp_t    exp_q[$];
  logic [DW-1:0] dst_q[$];
  int      gseq[$];
  longint  gcyc[$];
  longint  cyc = 0;
  int      m_ptr = NUM_REQ - 1;
  longint  next_ok = 0;
  bit      dst_en = 1'b0;
  int      dst_pulses = 0;

  sync_bus_scheduler #(
    .NUM_REQ(NUM_REQ), .data_width(DW), .ENABLE_CYCLES(EN), .HOLD_CYCLES(HOLDC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .bus_enable (bus_enable),
    .unsync_bus (unsync_bus),
    .busy       (busy),
    .last_src   (last_src)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #4 clk_dst = ~clk_dst;
  end

  always_comb begin
    req_data = '0;
    for (int k = 0; k < NUM_REQ; k++) req_data[k*DW +: DW] = words[k];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a launch may start once PERIOD cycles have passed since the last
  // one; the winner is the first requester after the previous winner.
  always @(posedge clk) begin
    if (rst) begin
      m_ptr   = NUM_REQ - 1;
      next_ok = 0;
      exp_q.delete();
    end else if (cyc >= next_ok && req != '0) begin
      int pick;
      pick = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        int c;
        c = (m_ptr + i) % NUM_REQ;
        if (pick < 0 && ((req >> c) & 1) != 0) pick = c;
      end
      exp_q.push_back('{pick, words[pick]});
      if (dst_en) dst_q.push_back(words[pick]);
      m_ptr   = pick;
      next_ok = cyc + PERIOD;
    end
    cyc++;
  end

  int            since = 1000;
  logic [DW-1:0] exp_bus = '0;
  int            exp_last = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      since    = 1000;
      exp_bus  = '0;
      exp_last = 0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_onehot", grant, 64'(1) << e.idx);
        since    = 0;
        exp_bus  = e.word;
        exp_last = e.idx;
        gseq.push_back(e.idx);
        gcyc.push_back(cyc);
      end else begin
        chk("no_spurious_grant", grant, 0);
        if (since < 1000) since++;
      end
      chk("bus_enable", bus_enable, (since < EN) ? 1 : 0);
      chk("busy", busy, (since < EN + HOLDC) ? 1 : 0);
      chk("unsync_bus", unsync_bus, exp_bus);
      chk("last_src", last_src, exp_last);
    end
  end

  logic [2:0] en_sync = '0;
  logic       en_prev = 1'b0;
  always @(posedge clk_dst) begin
    en_sync <= {en_sync[1:0], bus_enable};
    en_prev <= en_sync[2];
    if (dst_en && en_sync[2] && !en_prev) begin
      dst_pulses++;
      if (dst_q.size() == 0) chk("dst_extra_pulse", 1, 0);
      else chk("dst_sync_bus", unsync_bus, dst_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k] && !keep[k]) req[k] = 1'b0;
      if (!req[k]) words[k] = DW'($urandom);
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int start;
    bit ok;
    start = gseq.size();
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      tick();
      if (gseq.size() >= start + n) ok = 1'b1;
    end
    chk("grant_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1);
  endtask

  initial begin
    int b;
    int n;
    int k;
    int exp_a[5];
    logic [DW-1:0] list [10];
    exp_a = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 10; i++) list[i] = (i < 9) ? DW'(8'h11 * (i + 1)) : 8'h9A;

    rst  = 1'b1;
    req  = '0;
    keep = '0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = DW'($urandom);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_bus_enable", bus_enable, 0);
    chk("rst_unsync_bus", unsync_bus, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_src", last_src, 0);
    rst = 1'b0;

    // All four requesting from reset: rotation starts at requester 0.
    b = gseq.size();
    keep = '1;
    req  = '1;
    run_until(5, 60);
    req  = '0;
    keep = '0;
    for (int i = 0; i < 5; i++) chk("a_order", gseq[b+i], exp_a[i]);
    for (int i = 1; i < 5; i++) chk("a_spacing", gcyc[b+i] - gcyc[b+i-1], PERIOD);
    wait_idle();

    // Single requester holding req: re-granted every PERIOD cycles.
    b = gseq.size();
    words[2] = 8'h3C;
    keep = 4'b0100;
    req  = 4'b0100;
    run_until(3, 40);
    req  = '0;
    keep = '0;
    for (int i = 0; i < 3; i++) chk("b_src", gseq[b+i], 2);
    for (int i = 1; i < 3; i++) chk("b_spacing", gcyc[b+i] - gcyc[b+i-1], PERIOD);
    wait_idle();

    // Fairness after a grant to requester 1.
    req = 4'b0010;
    run_until(1, 20);
    wait_idle();
    b = gseq.size();
    keep = 4'b1010;
    req  = 4'b1010;
    run_until(3, 40);
    req  = '0;
    keep = '0;
    chk("c_first", gseq[b], 3);
    chk("c_second", gseq[b+1], 1);
    chk("c_third", gseq[b+2], 3);
    wait_idle();

    // Request pulsed and withdrawn while busy is never served.
    req = 4'b0010;
    run_until(1, 20);
    b = gseq.size();
    tick();
    tick();
    req[0] = 1'b1;
    tick();
    tick();
    req[0] = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("d_no_grant_dropped_req", gseq.size(), b);

    // Request arriving in the last HOLD cycle is served in the next IDLE cycle.
    req = 4'b0100;
    run_until(1, 20);
    b = gseq.size();
    repeat (6) tick();
    req[3] = 1'b1;
    run_until(1, 20);
    chk("d_late_src", gseq[b], 3);
    chk("d_late_spacing", gcyc[b] - gcyc[b-1], PERIOD);
    wait_idle();

    // Asynchronous reset in the middle of HOLD.
    req = 4'b1000;
    run_until(1, 20);
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    chk("e_rst_grant", grant, 0);
    chk("e_rst_bus_enable", bus_enable, 0);
    chk("e_rst_unsync_bus", unsync_bus, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_last_src", last_src, 0);
    tick();
    b = gseq.size();
    words[0] = 8'hA5;
    req = 4'b0001;
    rst = 1'b0;
    run_until(1, 10);
    chk("e_after_rst_src", gseq[b], 0);
    wait_idle();

    // Closed loop: ten words from random sources through the destination capture.
    dst_en = 1'b1;
    dst_pulses = 0;
    b = gseq.size();
    n = 0;
    for (int t = 0; t < 600 && !(n == 10 && req == '0); t++) begin
      if (n < 10 && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, NUM_REQ - 1));
        if (!req[k]) begin
          words[k] = list[n];
          req[k]   = 1'b1;
          n++;
        end
      end
      tick();
    end
    chk("f_issue_done", (n == 10 && req == '0) ? 1 : 0, 1);
    wait_idle();
    repeat (8) tick();
    dst_en = 1'b0;
    chk("f_grants", gseq.size() - b, 10);
    chk("f_dst_pulses", dst_pulses, 10);
    chk("f_dst_q_drained", dst_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
